// File: rtl/thread_disp_rsp_pkg.sv
// Shared definitions for the thread FORK/STOP dispatcher responder.
// Message codes, address/data widths, header spacing and FSM state encodings.
// No logic of its own; imported by the responder and its helpers.
package thread_disp_rsp_pkg;

  localparam int ADDR_SIZE = 16;
  localparam int DATA_SIZE = 16;

  // Inter-CPU message codes; 8'h00 is the idle code on the reply bus.
  localparam logic [7:0] CPU_R_FORK_THRD = 8'h21;
  localparam logic [7:0] CPU_R_STOP_THRD = 8'h22;
  localparam logic [7:0] CPU_R_FORK_DONE = 8'h31;
  localparam logic [7:0] CPU_R_STOP_DONE = 8'h32;

  // STOP carries the thread header address; the code starts this far above it.
  localparam logic [ADDR_SIZE-1:0] THREAD_HEADER_SPACE = 16'h0010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FORK_W = 3'd1,
    ST_STOP_W = 3'd2,
    ST_REPLY  = 3'd3,
    ST_DRAIN  = 3'd4
  } disp_state_t;

  // Code address addressed by a STOP whose payload is a header address.
  function automatic logic [ADDR_SIZE-1:0] stop_target(input logic [ADDR_SIZE-1:0] hdr_addr);
    return hdr_addr + THREAD_HEADER_SPACE;
  endfunction

endpackage

// File: rtl/thread_rr_pick.sv
// Rotating priority encoder: first set bit of vec searching upward from start+1 (wrapping).
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are stable.
module thread_rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk start+1 .. start+N; N is a power of two so the index wraps naturally.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = start + IW'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_disp_rsp.sv
// Dispatcher responder: FORK/STOP thread-table updates with DONE replies, plus round-robin scheduler read port.
// Latency: table update 1 cycle after request, DONE for REPLY_CYCLES after that; scheduler ack 1 cycle after sched_req.
// Backpressure: requests are held by the initiator until DRAIN sees the code drop; sched_req waits while a message is active.
module thread_disp_rsp
  import thread_disp_rsp_pkg::*;
#(
  parameter int THREADS      = 8,
  parameter int REPLY_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      disp_online,
  input  logic [7:0]                cpu_msg_in,
  output logic [7:0]                cpu_msg_out,
  output logic                      cpu_msg_oe,
  input  logic [ADDR_SIZE-1:0]      addr_in,
  input  logic [DATA_SIZE-1:0]      data_in,
  input  logic                      sched_req,
  output logic                      sched_ack,
  output logic                      sched_valid,
  output logic [ADDR_SIZE-1:0]      sched_addr,
  output logic [DATA_SIZE-1:0]      sched_data,
  output logic [$clog2(THREADS):0]  thread_cnt,
  output logic                      fork_ovf,
  output logic                      stop_miss
);

  localparam int IW = $clog2(THREADS);
  localparam int CW = IW + 1;
  localparam int RW = (REPLY_CYCLES > 1) ? $clog2(REPLY_CYCLES) : 1;

  disp_state_t          state, state_nx;
  logic [ADDR_SIZE-1:0] addr_l;
  logic [DATA_SIZE-1:0] data_l;
  logic                 req_is_stop;
  logic [RW-1:0]        reply_cnt;

  logic [THREADS-1:0]   tbl_vld;
  logic [ADDR_SIZE-1:0] tbl_addr [THREADS];
  logic [DATA_SIZE-1:0] tbl_data [THREADS];
  logic [IW-1:0]        rr_ptr;

  logic                 is_fork, is_stop, sched_go;
  logic                 alloc_found, pick_found;
  logic [IW-1:0]        alloc_idx, pick_idx;
  logic [THREADS-1:0]   stop_hit;
  logic [CW-1:0]        stop_cnt;

  // Lowest free slot: scanning the free vector from THREADS-1 starts the search at slot 0.
  thread_rr_pick #(.N(THREADS)) u_alloc (
    .vec   (~tbl_vld),
    .start (IW'(THREADS - 1)),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  // Next runnable thread after the last one served.
  thread_rr_pick #(.N(THREADS)) u_sched (
    .vec   (tbl_vld),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Request decode and STOP match vector with its population count.
  always_comb begin
    is_fork  = (cpu_msg_in == CPU_R_FORK_THRD);
    is_stop  = (cpu_msg_in == CPU_R_STOP_THRD);
    stop_hit = '0;
    stop_cnt = '0;
    for (int i = 0; i < THREADS; i++) begin
      stop_hit[i] = tbl_vld[i] && (tbl_addr[i] == stop_target(addr_l));
      stop_cnt    = stop_cnt + {{IW{1'b0}}, stop_hit[i]};
    end
  end

  // State register; reset aborts any transaction without a reply.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and reply bus; messages take priority over the scheduler.
  always_comb begin
    state_nx    = state;
    cpu_msg_out = 8'h00;
    cpu_msg_oe  = 1'b0;
    sched_go    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_fork)                       state_nx = ST_FORK_W;
        else if (is_stop)                  state_nx = ST_STOP_W;
        else if (sched_req && !sched_ack)  sched_go = 1'b1;
      end
      ST_FORK_W, ST_STOP_W: state_nx = ST_REPLY;
      ST_REPLY: begin
        cpu_msg_oe  = 1'b1;
        cpu_msg_out = req_is_stop ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
        if (reply_cnt == RW'(REPLY_CYCLES - 1)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cpu_msg_in != (req_is_stop ? CPU_R_STOP_THRD : CPU_R_FORK_THRD)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control state: request latch, table valid bits, counters, sticky flags, scheduler outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_online <= 1'b0;
      addr_l      <= '0;
      data_l      <= '0;
      req_is_stop <= 1'b0;
      reply_cnt   <= '0;
      tbl_vld     <= '0;
      thread_cnt  <= '0;
      fork_ovf    <= 1'b0;
      stop_miss   <= 1'b0;
      rr_ptr      <= IW'(THREADS - 1);
      sched_ack   <= 1'b0;
      sched_valid <= 1'b0;
      sched_addr  <= '0;
      sched_data  <= '0;
    end else begin
      disp_online <= 1'b1;
      sched_ack   <= sched_go;
      if (state == ST_IDLE && (is_fork || is_stop)) begin
        addr_l      <= addr_in;
        data_l      <= data_in;
        req_is_stop <= is_stop;
      end
      if (state == ST_FORK_W) begin
        if (alloc_found) begin
          tbl_vld[alloc_idx] <= 1'b1;
          thread_cnt         <= thread_cnt + CW'(1);
        end else begin
          fork_ovf <= 1'b1;
        end
      end
      if (state == ST_STOP_W) begin
        tbl_vld    <= tbl_vld & ~stop_hit;
        thread_cnt <= thread_cnt - stop_cnt;
        if (stop_hit == '0) stop_miss <= 1'b1;
      end
      reply_cnt <= (state == ST_REPLY) ? reply_cnt + RW'(1) : '0;
      if (sched_go) begin
        sched_valid <= pick_found;
        sched_addr  <= pick_found ? tbl_addr[pick_idx] : '0;
        sched_data  <= pick_found ? tbl_data[pick_idx] : '0;
        if (pick_found) rr_ptr <= pick_idx;
      end
    end
  end

  // Table payload; only meaningful where the valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_FORK_W && alloc_found) begin
      tbl_addr[alloc_idx] <= addr_l;
      tbl_data[alloc_idx] <= data_l;
    end
  end

endmodule
